// File: rtl/keccak_pad_blk_if.sv
// keccak_pad_blk_if: word-in / lane-out handshake bundle for the Keccak padder
interface keccak_pad_blk_if;
  logic        pushin;
  logic        stopin;
  logic [63:0] din;
  logic [3:0]  nbytes;
  logic        lastin;
  logic        pushout;
  logic        stopout;
  logic        firstout;
  logic        lastout;
  logic [63:0] dout;
  modport master (output pushin, din, nbytes, lastin, stopout, input stopin, pushout, firstout, lastout, dout);
  modport slave (input pushin, din, nbytes, lastin, stopout, output stopin, pushout, firstout, lastout, dout);
endinterface

// File: rtl/keccak_pad_blk.sv
// keccak_pad_blk: multi-rate padder that forms 25-lane blocks in perm_blk lane order
module keccak_pad_blk #(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] PAD_BYTE   = 8'h06
) (
  input logic            clk,
  input logic            rst,
  keccak_pad_blk_if.slave bus
);
  localparam logic [4:0] RL  = 5'(RATE_LANES);
  localparam logic [4:0] RLM = 5'(RATE_LANES - 1);
  typedef enum logic [1:0] {FILL, PAD, DRAIN} state_t;
  state_t      r_state;
  logic [63:0] r_buf [32];
  logic [4:0]  r_widx, r_plane;
  logic [2:0]  r_pbyte, r_x, r_y;
  logic        r_final, r_pend;
  logic        r_stopin, r_pushout, r_firstout, r_lastout;
  logic [63:0] r_dout;
  logic [3:0]  w_n;
  logic [63:0] w_mask, w_lane;
  logic [2:0]  w_nx, w_ny;
  logic [4:0]  w_idx;
  logic        w_adv, w_end;
  assign bus.stopin   = r_stopin;
  assign bus.pushout  = r_pushout;
  assign bus.firstout = r_firstout;
  assign bus.lastout  = r_lastout;
  assign bus.dout     = r_dout;
  // Emission walks x outer / y inner; the buffer is addressed by x+5y
  always_comb begin
    w_n    = (!bus.lastin || bus.nbytes > 4'd8) ? 4'd8 : bus.nbytes;
    w_mask = ~({64{1'b1}} << {w_n, 3'b000});
    w_adv  = r_state == DRAIN && (!r_pushout || !bus.stopout);
    w_end  = r_pushout && r_x == 3'd4 && r_y == 3'd4;
    w_ny   = (!r_pushout || r_y == 3'd4) ? 3'd0 : r_y + 3'd1;
    w_nx   = !r_pushout ? 3'd0 : (r_y == 3'd4 ? r_x + 3'd1 : r_x);
    w_idx  = {2'b00, w_nx} + {2'b00, w_ny} * 5'd5;
    w_lane = w_idx < RL ? r_buf[w_idx] : 64'h0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      for (int i = 0; i < 32; i++) r_buf[i] <= '0;
      r_widx     <= '0;
      r_plane    <= '0;
      r_pbyte    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_final    <= 1'b0;
      r_pend     <= 1'b0;
      r_stopin   <= 1'b0;
      r_pushout  <= 1'b0;
      r_firstout <= 1'b0;
      r_lastout  <= 1'b0;
      r_dout     <= '0;
    end else begin
      case (r_state)
        FILL: if (bus.pushin) begin
          r_buf[r_widx] <= r_buf[r_widx] | (bus.din & w_mask);
          r_widx        <= r_widx + 5'd1;
          if (bus.lastin) begin
            r_plane  <= w_n == 4'd8 ? r_widx + 5'd1 : r_widx;
            r_pbyte  <= w_n[2:0];
            r_state  <= PAD;
            r_stopin <= 1'b1;
          end else if (r_widx == RLM) begin
            r_final  <= 1'b0;
            r_state  <= DRAIN;
            r_stopin <= 1'b1;
          end
        end
        PAD: begin
          // A message ending on a block boundary gets a whole pad-only block next
          if (r_plane < RL)
            for (int i = 0; i < 32; i++)
              r_buf[i] <= r_buf[i] | (5'(i) == r_plane ? {56'h0, PAD_BYTE} << {r_pbyte, 3'b000} : 64'h0)
                                   | (5'(i) == RLM ? 64'h8000_0000_0000_0000 : 64'h0);
          r_final <= r_plane < RL;
          r_pend  <= !(r_plane < RL);
          r_plane <= '0;
          r_pbyte <= '0;
          r_state <= DRAIN;
        end
        DRAIN: if (w_adv) begin
          if (w_end) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= '0;
            r_widx     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_pushout  <= 1'b0;
            r_firstout <= 1'b0;
            r_lastout  <= 1'b0;
            r_dout     <= '0;
            r_pend     <= 1'b0;
            r_stopin   <= r_pend;
            r_state    <= r_pend ? PAD : FILL;
          end else begin
            r_x        <= w_nx;
            r_y        <= w_ny;
            r_pushout  <= 1'b1;
            r_dout     <= w_lane;
            r_firstout <= w_nx == 3'd0 && w_ny == 3'd0;
            r_lastout  <= r_final && w_nx == 3'd4 && w_ny == 3'd4;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_pad_blk.sv
// tb_keccak_pad_blk: directed and random messages checked against a byte-level padding model
module tb_keccak_pad_blk;
  localparam int RATE = 17;
  localparam logic [7:0] PADB = 8'h06;
  typedef logic [7:0] bq_t[$];
  logic clk, rst;
  keccak_pad_blk_if ifc ();
  keccak_pad_blk #(.RATE_LANES(RATE), .PAD_BYTE(PADB)) dut (.clk(clk), .rst(rst), .bus(ifc));
  int n_checks = 0, n_fail = 0;
  logic [63:0] exp_d[$];
  logic exp_f[$], exp_l[$];
  logic [63:0] cap_d[25];
  logic cap_f[25], cap_l[25];
  int mon_e = 0, hold_cnt = 0;
  bit stall_mode = 0, gap_mode = 0, hold_req = 0, prev_stall = 0;
  logic [63:0] pv_d;
  logic pv_f, pv_l;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  // Reference: pad the byte string to a multiple of the rate, then slice into lanes
  task automatic model(input bq_t m);
    int rb, len, plen, nb, idx;
    logic [7:0] p[];
    logic [63:0] lane;
    rb = RATE * 8;
    len = m.size();
    plen = len + (rb - len % rb);
    p = new[plen];
    foreach (p[i]) p[i] = (i < len) ? m[i] : 8'h00;
    p[len] = p[len] | PADB;
    p[plen-1] = p[plen-1] | 8'h80;
    nb = plen / rb;
    for (int b = 0; b < nb; b++)
      for (int e = 0; e < 25; e++) begin
        idx = e / 5 + 5 * (e % 5);
        lane = '0;
        if (idx < RATE)
          for (int k = 0; k < 8; k++) lane[8*k +: 8] = p[b*rb + 8*idx + k];
        exp_d.push_back(lane);
        exp_f.push_back(e == 0);
        exp_l.push_back(b == nb - 1 && e == 24);
      end
  endtask
  task automatic send_msg(input bq_t m, input int lat_w, output int lat);
    int nw, nb;
    logic [63:0] d;
    bit last;
    nw = (m.size() + 7) / 8;
    if (nw == 0) nw = 1;
    lat = 0;
    for (int w = 0; w < nw; w++) begin
      d = {$urandom, $urandom};
      nb = 0;
      last = (w == nw - 1);
      for (int b = 0; b < 8; b++)
        if (8*w + b < m.size()) begin
          d[8*b +: 8] = m[8*w + b];
          nb++;
        end
      if (gap_mode) repeat ($urandom_range(0, 2)) begin @(negedge clk); ifc.pushin = 1'b0; end
      @(negedge clk);
      ifc.pushin = 1'b1;
      ifc.din = d;
      ifc.lastin = last;
      ifc.nbytes = last ? (nb == 8 ? 4'(8 + $urandom_range(0, 7)) : 4'(nb)) : 4'($urandom_range(0, 15));
      while (ifc.stopin) @(negedge clk);
      if (w == lat_w) begin
        @(negedge clk);
        ifc.pushin = 1'b0;
        lat = 1;
        while (!ifc.pushout && lat < 10) begin @(negedge clk); lat++; end
      end
    end
    @(negedge clk);
    ifc.pushin = 1'b0;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_d.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    n_checks++;
    assert (exp_d.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d lanes pending expected 0", exp_d.size());
    end
  endtask
  always @(negedge clk) begin : mon
    logic s, h;
    if (!rst) begin
      h = hold_req && mon_e == 7 && ifc.pushout && hold_cnt < 5;
      s = h || (stall_mode && $urandom_range(0, 3) == 0);
      if (h) hold_cnt++;
      if (prev_stall) begin
        chk("hold_dout", ifc.dout, pv_d);
        chk("hold_firstout", 64'(ifc.firstout), 64'(pv_f));
        chk("hold_lastout", 64'(ifc.lastout), 64'(pv_l));
      end
      if (ifc.pushout) chk("stopin_in_drain", 64'(ifc.stopin), 64'd1);
      if (ifc.pushout && !s) begin
        n_checks++;
        assert (exp_d.size() != 0) else begin
          n_fail++;
          $error("FAIL extra_lane: observed lane %h expected none", ifc.dout);
        end
        if (exp_d.size() != 0) begin
          chk("dout", ifc.dout, exp_d.pop_front());
          chk("firstout", 64'(ifc.firstout), 64'(exp_f.pop_front()));
          chk("lastout", 64'(ifc.lastout), 64'(exp_l.pop_front()));
        end
        cap_d[mon_e] = ifc.dout;
        cap_f[mon_e] = ifc.firstout;
        cap_l[mon_e] = ifc.lastout;
        mon_e = mon_e == 24 ? 0 : mon_e + 1;
      end
      prev_stall = ifc.pushout && s;
      pv_d = ifc.dout;
      pv_f = ifc.firstout;
      pv_l = ifc.lastout;
      ifc.stopout = s;
    end
  end
  initial begin
    bq_t m;
    int lat, t;
    rst = 1'b1;
    ifc.pushin = 1'b0;
    ifc.din = '0;
    ifc.nbytes = '0;
    ifc.lastin = 1'b0;
    ifc.stopout = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stopin", 64'(ifc.stopin), 64'd0);
    chk("rst_pushout", 64'(ifc.pushout), 64'd0);
    chk("rst_firstout", 64'(ifc.firstout), 64'd0);
    chk("rst_lastout", 64'(ifc.lastout), 64'd0);
    chk("rst_dout", ifc.dout, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m = {};
    model(m);
    send_msg(m, 0, lat);
    wait_idle();
    chk("empty_lat", 64'(lat), 64'd3);
    chk("empty_e0", cap_d[0], 64'h06);
    chk("empty_first0", 64'(cap_f[0]), 64'd1);
    chk("empty_e8", cap_d[8], 64'h8000_0000_0000_0000);
    chk("empty_last23", 64'(cap_l[23]), 64'd0);
    chk("empty_last24", 64'(cap_l[24]), 64'd1);
    m = {8'h61, 8'h62, 8'h63};
    model(m);
    send_msg(m, 0, lat);
    wait_idle();
    chk("abc_lat", 64'(lat), 64'd3);
    chk("abc_e0", cap_d[0], 64'h0000_0000_0663_6261);
    chk("abc_e8", cap_d[8], 64'h8000_0000_0000_0000);
    m = {};
    for (int i = 0; i < 128; i++) m.push_back(8'($urandom));
    m = {m, 8'h11, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    model(m);
    send_msg(m, -1, lat);
    wait_idle();
    chk("w16p7_e8", cap_d[8], 64'h86AA_BBCC_DDEE_FF11);
    chk("w16p7_last", 64'(cap_l[24]), 64'd1);
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'($urandom));
    model(m);
    send_msg(m, 16, lat);
    wait_idle();
    chk("w17_lat", 64'(lat), 64'd3);
    chk("w17_b2_e0", cap_d[0], 64'h06);
    chk("w17_b2_e8", cap_d[8], 64'h8000_0000_0000_0000);
    chk("w17_b2_last", 64'(cap_l[24]), 64'd1);
    hold_req = 1;
    hold_cnt = 0;
    m = {};
    for (int i = 0; i < 160; i++) m.push_back(8'($urandom));
    model(m);
    send_msg(m, 16, lat);
    wait_idle();
    chk("fill_lat", 64'(lat), 64'd2);
    chk("hold_cycles", 64'(hold_cnt), 64'd5);
    hold_req = 0;
    stall_mode = 1;
    gap_mode = 1;
    for (int k = 0; k < 25; k++) begin
      m = {};
      repeat ($urandom_range(0, 400)) m.push_back(8'($urandom));
      model(m);
      send_msg(m, -1, lat);
    end
    wait_idle();
    stall_mode = 0;
    gap_mode = 0;
    m = {};
    for (int i = 0; i < 80; i++) m.push_back(8'($urandom | 1));
    model(m);
    send_msg(m, -1, lat);
    t = 0;
    while (!(mon_e == 12 && ifc.pushout) && t < 2000) begin @(negedge clk); t++; end
    chk("reach_e12", 64'(mon_e), 64'd12);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stopin", 64'(ifc.stopin), 64'd0);
    chk("mid_rst_pushout", 64'(ifc.pushout), 64'd0);
    chk("mid_rst_firstout", 64'(ifc.firstout), 64'd0);
    chk("mid_rst_lastout", 64'(ifc.lastout), 64'd0);
    chk("mid_rst_dout", ifc.dout, 64'd0);
    exp_d.delete();
    exp_f.delete();
    exp_l.delete();
    mon_e = 0;
    prev_stall = 0;
    ifc.stopout = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(ifc.pushout), 64'd0);
    end
    m = {};
    model(m);
    send_msg(m, -1, lat);
    wait_idle();
    chk("clean_e0", cap_d[0], 64'h06);
    chk("clean_e1", cap_d[1], 64'h0);
    chk("clean_e8", cap_d[8], 64'h8000_0000_0000_0000);
    chk("clean_last", 64'(cap_l[24]), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
